fetch_hazard_ctrl: RTL and testbench
====================================

Name: fetch_hazard_ctrl

Overview:
- Pipeline control block driving the IF stage's redirect, stall and squash inputs: npc, pc_stall_en, Flush.
- Also produces the IF/ID hold and ID/EX bubble controls.
- Resolves load-use hazards, EX-stage branch/jump redirects and multi-cycle mult/div busy interlocks.
- Holds a small FSM and cycle counter that track the in-flight HI/LO operation.

Parameters:
MD_CYCLES, 32, cycles a mult/div occupies the HI/LO unit after start (legal range >= 1)
NO_REDIRECT, 32'hFFFF_FFFF, npc value meaning "no redirect, fetch PC+4"

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_uses_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo) or starts a mult/div
ex_mem_read  in  1  EX instruction is a load
ex_rt  in  5  destination of EX load
ex_md_start  in  1  EX instruction starts mult/div this cycle
ex_redirect  in  1  EX resolved taken branch/jump this cycle
ex_target  in  32  redirect target
npc  out  32  redirect PC to IF; NO_REDIRECT when none
pc_stall_en  out  1  hold PC
if_id_stall  out  1  hold IF/ID register
Flush  out  1  squash instruction fetched this cycle
id_ex_bubble  out  1  insert NOP into ID/EX
md_busy  out  1  HI/LO unit occupied
md_err  out  1  sticky: ex_md_start seen while busy

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset state and outputs: state=RUN, cnt=0, md_err=0. While rst is high, all outputs are inactive: npc=NO_REDIRECT, all 1-bit outputs 0.
- FSM states:
  - RUN: ex_md_start moves to MD_BUSY and loads cnt=MD_CYCLES-1.
  - MD_BUSY: if cnt==0, go to RUN; else cnt-1.
  - md_busy=1 exactly in MD_BUSY, so it is high for MD_CYCLES cycles, starting the cycle after ex_md_start.
- Counter: width max(1,$clog2(MD_CYCLES)). MD_CYCLES=1 gives a single busy cycle (cnt loads 0).
- ex_md_start while in MD_BUSY:
  - Sets md_err, which stays set until rst.
  - Counter is not reloaded; the current operation continues.
- Hazard terms (combinational, all 5-bit compares):
  - lu = ex_mem_read && ex_rt!=0 && ((id_uses_rs && id_rs==ex_rt) || (id_uses_rt && id_rt==ex_rt)).
  - md = md_busy && id_uses_hilo.
  - Unregistered: the hazard output reacts in the same cycle as the hazard inputs.
- Priority (same-cycle outputs):
  - 1. ex_redirect=1: npc=ex_target, Flush=1, id_ex_bubble=1, pc_stall_en=0, if_id_stall=0. Redirect overrides any stall, since the stalled ID instruction is on the wrong path.
  - 2. Else lu or md: pc_stall_en=1, if_id_stall=1, id_ex_bubble=1, Flush=0, npc=NO_REDIRECT.
  - 3. Else all inactive, npc=NO_REDIRECT.
- Stall duration:
  - Load-use stalls exactly 1 cycle, because the load leaves EX.
  - md stalls until the cycle after md_busy falls.
- Simultaneous events:
  - ex_redirect together with ex_md_start: redirect outputs are applied, and the FSM still enters MD_BUSY. The mult/div in EX is older and is architecturally valid.
  - ex_target==32'hFFFF_FFFF is illegal (collides with NO_REDIRECT); it is not checked.
- Reset mid-operation: asynchronous return to RUN. md_busy, md_err and cnt clear immediately and all outputs deassert.

Decomposition:
- Shared package: NO_REDIRECT constant; FSM state typedef {RUN, MD_BUSY}; 5-bit register-index type.
- One natural sub-module: md_busy_timer (FSM, counter, md_err). The top is the combinational hazard/priority logic.

Test Plan:
- Reset: assert rst mid-MD_BUSY at cnt=10 -> md_busy=0, md_err=0, npc=FFFF_FFFF immediately; after release, idle outputs hold.
- Load-use: ex_mem_read=1, ex_rt=5, id_uses_rs=1, id_rs=5 -> pc_stall_en=if_id_stall=id_ex_bubble=1 for one cycle. Repeat with ex_rt=0 -> no stall.
- Mult/div: MD_CYCLES=4, pulse ex_md_start, hold id_uses_hilo=1 -> md_busy high cycles 1-4, stall high cycles 1-4, stall low in cycle 5.
- Redirect vs stall: load-use hazard plus ex_redirect=1, ex_target=32'h0000_3040 in same cycle -> npc=32'h0000_3040, Flush=1, id_ex_bubble=1, pc_stall_en=0.
- Error: ex_md_start during MD_BUSY at cnt=2 -> md_err=1 sticky; busy ends on the original schedule.
- MD_CYCLES=1 build: ex_md_start -> md_busy high exactly 1 cycle.

Source files
------------

// File: rtl/fetch_hazard_ctrl_pkg.sv
// fetch_hazard_ctrl_pkg
//   Shared types and constants for the fetch hazard controller slice.
//   - NO_REDIRECT : npc value meaning "no redirect, fetch PC+4"
//   - md_state_e  : HI/LO unit occupancy FSM states
//   - reg_idx_t   : 5-bit architectural register index
//   - md_cnt_width: busy counter width, max(1, $clog2(md_cycles))
package fetch_hazard_ctrl_pkg;

    localparam logic [31:0] NO_REDIRECT = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        RUN,
        MD_BUSY
    } md_state_e;

    typedef logic [4:0] reg_idx_t;

    function automatic int unsigned md_cnt_width(input int unsigned md_cycles);
        return (md_cycles <= 2) ? 1 : $clog2(md_cycles);
    endfunction

endpackage

// File: rtl/fetch_hazard_ctrl_if.sv
// fetch_hazard_ctrl_if
//   Bundles the ID/EX hazard inputs and the IF/ID/EX control outputs.
//   - master : pipeline side, drives ID/EX status, receives controls
//   - slave  : hazard controller, reads status, drives controls
interface fetch_hazard_ctrl_if;
    import fetch_hazard_ctrl_pkg::*;

    reg_idx_t    id_rs;
    reg_idx_t    id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_uses_hilo;
    logic        ex_mem_read;
    reg_idx_t    ex_rt;
    logic        ex_md_start;
    logic        ex_redirect;
    logic [31:0] ex_target;

    logic [31:0] npc;
    logic        pc_stall_en;
    logic        if_id_stall;
    logic        Flush;
    logic        id_ex_bubble;
    logic        md_busy;
    logic        md_err;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_uses_hilo,
               ex_mem_read, ex_rt, ex_md_start, ex_redirect, ex_target,
        input  npc, pc_stall_en, if_id_stall, Flush, id_ex_bubble, md_busy, md_err
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_uses_hilo,
               ex_mem_read, ex_rt, ex_md_start, ex_redirect, ex_target,
        output npc, pc_stall_en, if_id_stall, Flush, id_ex_bubble, md_busy, md_err
    );

endinterface

// File: rtl/fetch_hazard_ctrl_md_busy_timer.sv
// fetch_hazard_ctrl_md_busy_timer
//   Tracks the in-flight mult/div: busy for MD_CYCLES cycles starting the
//   cycle after md_start_i. A start seen while busy is flagged in a sticky
//   error bit and does not restart the timer.
//   - clk, rst    : clock, asynchronous active-high reset
//   - md_start_i  : EX instruction starts a mult/div this cycle
//   - md_busy_o   : HI/LO unit occupied
//   - md_err_o    : sticky overlapping-start error
module fetch_hazard_ctrl_md_busy_timer
    import fetch_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start_i,
    output logic md_busy_o,
    output logic md_err_o
);

    localparam int unsigned CntW = md_cnt_width(MD_CYCLES);
    localparam logic [CntW-1:0] CntLoad = CntW'(MD_CYCLES - 1);

    md_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            RUN: begin
                if (md_start_i) begin
                    state_d = MD_BUSY;
                    cnt_d   = CntLoad;
                end
            end
            MD_BUSY: begin
                // Overlapping start: flag it, let the current operation finish.
                if (md_start_i) begin
                    err_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
        endcase
    end

    assign md_busy_o = (state_q == MD_BUSY);
    assign md_err_o  = err_q;

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// fetch_hazard_ctrl
//   IF-stage redirect/stall/squash control. Detects load-use and HI/LO busy
//   hazards on the ID instruction and prioritises EX redirects over stalls.
//   - clk, rst : clock, asynchronous active-high reset
//   - bus      : slave side of fetch_hazard_ctrl_if (ID/EX status in,
//                npc/pc_stall_en/if_id_stall/Flush/id_ex_bubble and
//                md_busy/md_err out)
module fetch_hazard_ctrl
    import fetch_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic                clk,
    input  logic                rst,
    fetch_hazard_ctrl_if.slave  bus
);

    logic md_busy;
    logic md_err;
    logic lu_hazard;
    logic md_hazard;

    fetch_hazard_ctrl_md_busy_timer #(
        .MD_CYCLES (MD_CYCLES)
    ) u_md_busy_timer (
        .clk        (clk),
        .rst        (rst),
        .md_start_i (bus.ex_md_start),
        .md_busy_o  (md_busy),
        .md_err_o   (md_err)
    );

    // r0 is hardwired zero, so a load into it never creates a dependency.
    assign lu_hazard = bus.ex_mem_read && (bus.ex_rt != '0) &&
                       ((bus.id_uses_rs && (bus.id_rs == bus.ex_rt)) ||
                        (bus.id_uses_rt && (bus.id_rt == bus.ex_rt)));

    assign md_hazard = md_busy && bus.id_uses_hilo;

    always_comb begin
        bus.npc          = NO_REDIRECT;
        bus.pc_stall_en  = 1'b0;
        bus.if_id_stall  = 1'b0;
        bus.Flush        = 1'b0;
        bus.id_ex_bubble = 1'b0;
        if (rst) begin
            // Outputs are combinational from inputs; force them idle in reset.
        end else if (bus.ex_redirect) begin
            // The stalled ID instruction is on the wrong path, so redirect wins.
            bus.npc          = bus.ex_target;
            bus.Flush        = 1'b1;
            bus.id_ex_bubble = 1'b1;
        end else if (lu_hazard || md_hazard) begin
            bus.pc_stall_en  = 1'b1;
            bus.if_id_stall  = 1'b1;
            bus.id_ex_bubble = 1'b1;
        end
    end

    assign bus.md_busy = md_busy;
    assign bus.md_err  = md_err;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
module tb_fetch_hazard_ctrl;
    import fetch_hazard_ctrl_pkg::*;

    localparam int NDUT = 3;

    function automatic int unsigned mdc(input int g);
        return (g == 0) ? 32 : (g == 1) ? 4 : 1;
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rs, id_uses_rt, id_uses_hilo;
    logic        ex_mem_read, ex_md_start, ex_redirect;
    logic [31:0] ex_target;

    // {npc, pc_stall_en, if_id_stall, Flush, id_ex_bubble, md_busy, md_err}
    logic [37:0] obs [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        fetch_hazard_ctrl_if bus ();

        assign bus.id_rs        = id_rs;
        assign bus.id_rt        = id_rt;
        assign bus.id_uses_rs   = id_uses_rs;
        assign bus.id_uses_rt   = id_uses_rt;
        assign bus.id_uses_hilo = id_uses_hilo;
        assign bus.ex_mem_read  = ex_mem_read;
        assign bus.ex_rt        = ex_rt;
        assign bus.ex_md_start  = ex_md_start;
        assign bus.ex_redirect  = ex_redirect;
        assign bus.ex_target    = ex_target;

        fetch_hazard_ctrl #(
            .MD_CYCLES ((g == 0) ? 32 : (g == 1) ? 4 : 1)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign obs[g] = {bus.npc, bus.pc_stall_en, bus.if_id_stall, bus.Flush,
                         bus.id_ex_bubble, bus.md_busy, bus.md_err};
    end

    // Reference model: remaining busy cycles per instance and sticky error.
    int unsigned rem [NDUT];
    bit          err [NDUT];

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    task automatic check(input string tag, input int g, input logic [31:0] o,
                         input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s[dut%0d]: observed %h expected %h", tag, g, o, e);
        end
    endtask

    task automatic check_all();
        for (int g = 0; g < NDUT; g++) begin
            bit          busy, lu, hz;
            logic [31:0] e_npc;
            bit          e_stall, e_flush, e_bub;
            busy = !rst && (rem[g] > 0);
            lu = ex_mem_read && (ex_rt != 0) &&
                 ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
            hz = lu || (busy && id_uses_hilo);
            e_npc = 32'hFFFF_FFFF;
            e_stall = 0; e_flush = 0; e_bub = 0;
            if (!rst) begin
                if (ex_redirect) begin
                    e_npc = ex_target; e_flush = 1; e_bub = 1;
                end else if (hz) begin
                    e_stall = 1; e_bub = 1;
                end
            end
            check("npc",          g, obs[g][37:6], e_npc);
            check("pc_stall_en",  g, 32'(obs[g][5]), 32'(e_stall));
            check("if_id_stall",  g, 32'(obs[g][4]), 32'(e_stall));
            check("Flush",        g, 32'(obs[g][3]), 32'(e_flush));
            check("id_ex_bubble", g, 32'(obs[g][2]), 32'(e_bub));
            check("md_busy",      g, 32'(obs[g][1]), 32'(busy));
            check("md_err",       g, 32'(obs[g][0]), 32'(!rst && err[g]));
        end
    endtask

    task automatic model_clock();
        for (int g = 0; g < NDUT; g++) begin
            if (rst) begin
                rem[g] = 0;
                err[g] = 0;
            end else if (rem[g] > 0) begin
                if (ex_md_start) err[g] = 1;
                rem[g] = rem[g] - 1;
            end else if (ex_md_start) begin
                rem[g] = mdc(g);
            end
        end
    endtask

    // Inputs are set just after a rising edge; outputs checked on the falling edge.
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_rt = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_uses_hilo = 0;
        ex_mem_read = 0; ex_md_start = 0; ex_redirect = 0;
        ex_target = 32'h0;
    endtask

    initial begin
        for (int g = 0; g < NDUT; g++) begin
            rem[g] = 0;
            err[g] = 0;
        end
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // Load-use on rs, then the load has left EX.
        ex_mem_read = 1; ex_rt = 5; id_uses_rs = 1; id_rs = 5;
        step();
        idle();
        id_uses_rs = 1; id_rs = 5;
        step();
        // Load into r0 never stalls.
        ex_mem_read = 1; ex_rt = 0; id_uses_rs = 1; id_rs = 0;
        step();
        // Load-use on rt.
        ex_mem_read = 1; ex_rt = 9; id_uses_rt = 1; id_rt = 9; id_uses_rs = 0;
        step();
        idle();

        // Mult/div busy interlock with a HI/LO reader waiting in ID.
        ex_md_start = 1;
        step();
        ex_md_start = 0; id_uses_hilo = 1;
        for (int i = 0; i < 6; i++) step();
        idle();
        for (int i = 0; i < 30; i++) step();

        // Redirect beats a same-cycle load-use stall.
        ex_mem_read = 1; ex_rt = 7; id_uses_rs = 1; id_rs = 7;
        ex_redirect = 1; ex_target = 32'h0000_3040;
        step();
        idle();

        // Overlapping start at cnt=2 on the 4-cycle build.
        ex_md_start = 1;
        step();
        ex_md_start = 0;
        step();
        ex_md_start = 1;
        step();
        ex_md_start = 0;
        for (int i = 0; i < 6; i++) step();
        for (int i = 0; i < 30; i++) step();

        // Asynchronous reset while the 32-cycle build has cnt=10.
        ex_md_start = 1;
        step();
        ex_md_start = 0;
        for (int i = 0; i < 21; i++) step();
        #2;
        rst = 1'b1;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            rem[g] = 0;
            err[g] = 0;
        end
        check_all();
        step();
        rst = 1'b0;
        step();
        step();

        // Randomised traffic including redirect + md_start collisions.
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 63) == 0);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_rt        = 5'($urandom_range(0, 3));
            id_uses_rs   = 1'($urandom);
            id_uses_rt   = 1'($urandom);
            id_uses_hilo = 1'($urandom);
            ex_mem_read  = 1'($urandom);
            ex_md_start  = ($urandom_range(0, 7) == 0);
            ex_redirect  = ($urandom_range(0, 4) == 0);
            ex_target    = $urandom & 32'h7FFF_FFFF;
            step();
        end
        rst = 1'b0;
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
